// File: rtl/fifo_rd_pkg.sv
// Shared types and helpers for the sync_fifo read-side master.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    localparam int unsigned RD_LAT = 1;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Small register FIFO holding words between the sync_fifo read port and the stream output.
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          clear,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         push_data,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         pop_data,
    output logic [clog2(DEPTH + 1)-1:0]   occ
);

    localparam int unsigned PTR_W = clog2(DEPTH);
    localparam int unsigned OCC_W = clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop   = pop && (occ != '0);
    assign pop_data = mem[rd_ptr];

    // Storage, pointers and occupancy; clear drops everything without touching storage.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, do_pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        (push && !clear) |-> (occ < OCC_W'(DEPTH)));

endmodule

// File: rtl/fifo_read_master.sv
// Drains sync_fifo into a valid/ready stream with burst tagging and flush sequencing.
// Optional FIFO_RD_WCNT_EN adds a words_drained transfer counter.
module fifo_read_master
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BURST      = 4,
    parameter int unsigned SKID_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  flush_req,
    output logic                  fifo_read_req,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    input  logic                  fifo_rdata_valid,
    input  logic                  fifo_empty,
    input  logic                  fifo_aempty,
    output logic                  fifo_flush,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
`ifdef FIFO_RD_WCNT_EN
    output logic [31:0]           words_drained,
`endif
    output logic                  busy
);

    localparam int unsigned OCC_W  = clog2(SKID_DEPTH + 1);
    localparam int unsigned INF_W  = clog2(RD_LAT + 1);
    localparam int unsigned FCNT_W = clog2(RD_LAT + 1);
    localparam int unsigned BCNT_W = clog2(BURST);
    localparam int unsigned CRED_W = clog2(SKID_DEPTH + RD_LAT + 1);

    state_t              state_q, state_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic [INF_W-1:0]    inflight_q, inflight_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic                flush_d;
    logic [OCC_W-1:0]    occ;
    logic                flushing;
    logic                clear;
    logic                push;
    logic                transfer;
    logic                idle_nx;
    logic [CRED_W-1:0]   credit_used;
    logic                unused_aempty;
`ifdef FIFO_RD_WCNT_EN
    logic [31:0]         wcnt_d;
`endif

    assign unused_aempty = fifo_aempty;

    assign flushing    = (state_q == FLUSH);
    assign clear       = flush_req || flushing;
    assign push        = fifo_rdata_valid && !flushing;
    assign out_valid   = (occ != '0);
    assign transfer    = out_valid && out_ready;
    assign out_last    = out_valid && (bcnt_q == BCNT_W'(BURST - 1));
    assign busy        = (state_q != IDLE);

    // Credit covers words already buffered plus words still returning from the FIFO.
    assign credit_used   = CRED_W'(occ) + CRED_W'(inflight_q);
    assign fifo_read_req = !flushing && enable && !fifo_empty
                           && (credit_used < CRED_W'(SKID_DEPTH));

    assign idle_nx = (inflight_d == '0)
                     && (((occ == '0) && !push)
                         || ((occ == OCC_W'(1)) && transfer && !push));

    fifo_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (SKID_DEPTH)
    ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .push      (push),
        .push_data (fifo_read_data),
        .pop       (transfer),
        .pop_data  (out_data),
        .occ       (occ)
    );

    // Next-state and counter updates; a flush request overrides everything else.
    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        flush_d    = 1'b0;
        inflight_d = inflight_q;
        bcnt_d     = bcnt_q;
`ifdef FIFO_RD_WCNT_EN
        wcnt_d     = words_drained;
`endif

        if (clear) begin
            inflight_d = '0;
        end else begin
            case ({fifo_read_req, fifo_rdata_valid})
                2'b10:   inflight_d = inflight_q + INF_W'(1);
                2'b01:   inflight_d = (inflight_q != '0) ? inflight_q - INF_W'(1) : '0;
                default: inflight_d = inflight_q;
            endcase
        end

        if (clear) begin
            bcnt_d = '0;
        end else if (transfer) begin
            bcnt_d = (bcnt_q == BCNT_W'(BURST - 1)) ? '0 : bcnt_q + BCNT_W'(1);
        end

`ifdef FIFO_RD_WCNT_EN
        if (clear) begin
            wcnt_d = '0;
        end else if (transfer) begin
            wcnt_d = words_drained + 32'd1;
        end
`endif

        if (flush_req) begin
            state_d = FLUSH;
            fcnt_d  = '0;
            flush_d = 1'b1;
        end else begin
            case (state_q)
                FLUSH: begin
                    if (fcnt_q == FCNT_W'(RD_LAT)) begin
                        state_d = IDLE;
                    end else begin
                        fcnt_d = fcnt_q + FCNT_W'(1);
                    end
                end
                default: state_d = idle_nx ? IDLE : ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            fcnt_q     <= '0;
            inflight_q <= '0;
            bcnt_q     <= '0;
            fifo_flush <= 1'b0;
`ifdef FIFO_RD_WCNT_EN
            words_drained <= '0;
`endif
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            inflight_q <= inflight_d;
            bcnt_q     <= bcnt_d;
            fifo_flush <= flush_d;
`ifdef FIFO_RD_WCNT_EN
            words_drained <= wcnt_d;
`endif
        end
    end

endmodule
